// File: rtl/life_engine_pkg.sv
// Shared types for the Conway life engine: word/address types and FSM states.
// Build option: define LIFE_WRAP_EN for a toroidal grid; otherwise cells outside the grid are dead.
package life_engine_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int LOG_MAX_ADDR = 6;

    typedef logic [LOG_MAX_ADDR-1:0] addr_t;
    typedef logic [WORD_SIZE-1:0]    data_t;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        WRITE,
        FETCH,
        WAIT,
        SWAP
    } state_t;

    // Conway rule for one cell from its eight neighbour bits
    function automatic logic next_cell(input logic [7:0] nbr, input logic live);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nbr[i]};
        end
        return (n == 4'd3) || (live && (n == 4'd2));
    endfunction

endpackage

// File: rtl/life_engine_if.sv
// Memory/double-buffer bus between the life engine and its row store.
// Build option: LIFE_WRAP_EN has no effect on this interface.
interface life_engine_if;
    import life_engine_pkg::*;

    addr_t logic_addr_r_out;
    data_t logic_data_r_in;
    addr_t logic_addr_w_out;
    data_t logic_data_w_out;
    logic  logic_wr_en_out;
    logic  swap_out;

    modport master (
        output logic_addr_r_out,
        input  logic_data_r_in,
        output logic_addr_w_out,
        output logic_data_w_out,
        output logic_wr_en_out,
        output swap_out
    );

    modport slave (
        input  logic_addr_r_out,
        output logic_data_r_in,
        input  logic_addr_w_out,
        input  logic_data_w_out,
        input  logic_wr_en_out,
        input  swap_out
    );

endinterface

// File: rtl/life_row_rule.sv
// Combinational next-generation row from the above/centre/below rows.
// Build option: LIFE_WRAP_EN wraps column -1 to WORD_SIZE-1 and column WORD_SIZE to 0.
module life_row_rule
    import life_engine_pkg::*;
(
    input  data_t above_in,
    input  data_t centre_in,
    input  data_t below_in,
    output data_t next_out
);

`ifdef LIFE_WRAP_EN
    function automatic data_t west(input data_t x);
        return {x[WORD_SIZE-2:0], x[WORD_SIZE-1]};
    endfunction

    function automatic data_t east(input data_t x);
        return {x[0], x[WORD_SIZE-1:1]};
    endfunction
`else
    function automatic data_t west(input data_t x);
        return {x[WORD_SIZE-2:0], 1'b0};
    endfunction

    function automatic data_t east(input data_t x);
        return {1'b0, x[WORD_SIZE-1:1]};
    endfunction
`endif

    data_t a_w, a_e, c_w, c_e, b_w, b_e;

    // bit c of west()/east() holds the cell at column c-1 / c+1
    always_comb begin
        a_w = west(above_in);
        a_e = east(above_in);
        c_w = west(centre_in);
        c_e = east(centre_in);
        b_w = west(below_in);
        b_e = east(below_in);
    end

    // apply the rule to every column of the centre row
    always_comb begin
        next_out = '0;
        for (int c = 0; c < WORD_SIZE; c++) begin
            next_out[c] = next_cell({a_w[c], above_in[c], a_e[c],
                                     c_w[c], c_e[c],
                                     b_w[c], below_in[c], b_e[c]},
                                    centre_in[c]);
        end
    end

endmodule

// File: rtl/life_engine.sv
// Row-streaming Conway life engine over a double-buffered row memory.
// Build option: LIFE_WRAP_EN makes the grid toroidal (rows and columns wrap).
module life_engine
    import life_engine_pkg::*;
#(
    parameter int ROWS         = 64,
    parameter int READ_LATENCY = 2
) (
    input  logic          clk_130mhz,
    input  logic          rst_n_in,
    input  logic          step_in,
    input  logic          ready_in,
    life_engine_if.master bus,
    output logic          busy_out,
    output logic [15:0]   gen_count_out
);

    localparam addr_t      LAST_ROW  = addr_t'(ROWS - 1);
    localparam logic [7:0] WAIT_LAST = 8'(READ_LATENCY - 1);

`ifdef LIFE_WRAP_EN
    localparam addr_t      PRIME_FIRST = LAST_ROW;
    localparam logic [1:0] PRIME_LEFT  = 2'd2;
`else
    localparam addr_t      PRIME_FIRST = '0;
    localparam logic [1:0] PRIME_LEFT  = 2'd1;
`endif

    function automatic addr_t row_add(input addr_t r, input int k);
        int s;
        s = int'(r) + k;
        if (s >= ROWS) begin
            s = s - ROWS;
        end
        return addr_t'(s);
    endfunction

    state_t      state_q, state_d;
    addr_t       row_q, row_d;
    addr_t       fetch_q, fetch_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  prime_q, prime_d;
    logic        priming_q, priming_d;
    data_t       above_q, above_d;
    data_t       centre_q, centre_d;
    data_t       below_q, below_d;
    logic [15:0] gen_q, gen_d;
    data_t       next_row;

    life_row_rule u_rule (
        .above_in  (above_q),
        .centre_in (centre_q),
        .below_in  (below_q),
        .next_out  (next_row)
    );

    // state, window and counters
    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            row_q     <= '0;
            fetch_q   <= '0;
            wait_q    <= '0;
            prime_q   <= '0;
            priming_q <= 1'b0;
            above_q   <= '0;
            centre_q  <= '0;
            below_q   <= '0;
            gen_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            fetch_q   <= fetch_d;
            wait_q    <= wait_d;
            prime_q   <= prime_d;
            priming_q <= priming_d;
            above_q   <= above_d;
            centre_q  <= centre_d;
            below_q   <= below_d;
            gen_q     <= gen_d;
        end
    end

    // sequencing: prime the window, then write one row / fetch one row
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        fetch_d   = fetch_q;
        wait_d    = wait_q;
        prime_d   = prime_q;
        priming_d = priming_q;
        above_d   = above_q;
        centre_d  = centre_q;
        below_d   = below_q;
        gen_d     = gen_q;
        unique case (state_q)
            IDLE: begin
                if (step_in && ready_in) begin
                    state_d   = PRIME;
                    row_d     = '0;
                    fetch_d   = PRIME_FIRST;
                    prime_d   = PRIME_LEFT;
                    priming_d = 1'b1;
                    above_d   = '0;
                    centre_d  = '0;
                    below_d   = '0;
                end
            end
            PRIME, FETCH: begin
                state_d = WAIT;
                wait_d  = WAIT_LAST;
            end
            WAIT: begin
                if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else begin
                    above_d  = centre_q;
                    centre_d = below_q;
                    below_d  = bus.logic_data_r_in;
                    if (priming_q && (prime_q != 2'd0)) begin
                        prime_d = prime_q - 2'd1;
                        fetch_d = row_add(fetch_q, 1);
                        state_d = PRIME;
                    end else begin
                        priming_d = 1'b0;
                        state_d   = WRITE;
                    end
                end
            end
            WRITE: begin
                if (row_q == LAST_ROW) begin
                    state_d = SWAP;
                end else begin
                    row_d = row_add(row_q, 1);
`ifdef LIFE_WRAP_EN
                    fetch_d = row_add(row_q, 2);
                    state_d = FETCH;
`else
                    // past the bottom edge the incoming row is dead
                    if (int'(row_q) >= ROWS - 2) begin
                        above_d  = centre_q;
                        centre_d = below_q;
                        below_d  = '0;
                        state_d  = WRITE;
                    end else begin
                        fetch_d = row_add(row_q, 2);
                        state_d = FETCH;
                    end
`endif
                end
            end
            SWAP: begin
                gen_d   = gen_q + 16'd1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // outputs decoded from the current state; zero outside their phase
    always_comb begin
        bus.logic_wr_en_out  = (state_q == WRITE);
        bus.logic_addr_w_out = (state_q == WRITE) ? row_q : '0;
        bus.logic_data_w_out = (state_q == WRITE) ? next_row : '0;
        bus.logic_addr_r_out = (state_q inside {PRIME, FETCH, WAIT}) ? fetch_q : '0;
        bus.swap_out         = (state_q == SWAP);
        busy_out             = (state_q != IDLE);
        gen_count_out        = gen_q;
    end

endmodule
